// File: rtl/simple_split_pkg.sv
// Shared definitions for the splitter valve controller: FSM state encoding
// and outlet select constants. The FLUSH state is present only when
// SIMPLE_SPLIT_CTRL_FLUSH_EN is defined.
package simple_split_pkg;

    localparam logic DEST_A = 1'b0;
    localparam logic DEST_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPEN  = 3'd1,
        ST_FLOW  = 3'd2,
        ST_CLOSE = 3'd3
`ifdef SIMPLE_SPLIT_CTRL_FLUSH_EN
        ,
        ST_FLUSH = 3'd4
`endif
    } split_state_e;

endpackage

// File: rtl/split_settle_timer.sv
// Loadable 8-bit down-counter with a zero flag. Used to time the valve
// settle phases. Counting stops at zero instead of wrapping.
module split_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [7:0] r_cnt;

    // Load has priority over decrement; hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/simple_split_ctrl.sv
// Splitter dispense controller: opens the selected outlet, waits for it to
// settle, holds the inlet open for cmd_vol cycles, then waits again before
// closing the outlet. Zero-volume commands are rejected with an err pulse.
// Optional feature macro: SIMPLE_SPLIT_CTRL_FLUSH_EN adds a FLUSH phase
// (inlet and new outlet open) when the outlet differs from the last one used.
module simple_split_ctrl #(
    parameter int SETTLE_CYC = 4,
    parameter int VOL_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dest,
    input  logic [VOL_W-1:0] cmd_vol,
    output logic             valve_in,
    output logic             valve_a,
    output logic             valve_b,
    output logic             busy,
    output logic             done,
    output logic             err
);

    import simple_split_pkg::*;

    // Each timed phase lasts SETTLE_CYC cycles: load N-1, leave on zero.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    split_state_e     r_state;
    split_state_e     w_state_next;
    logic             r_cmd_dest;
    logic [VOL_W-1:0] r_vol_cnt;

    logic r_cmd_ready;
    logic r_valve_in;
    logic r_valve_a;
    logic r_valve_b;
    logic r_busy;
    logic r_done;
    logic r_err;

    logic w_accept;
    logic w_cmd_start;
    logic w_cmd_reject;
    logic w_dest_next;
    logic w_vol_zero;
    logic w_timer_load;
    logic w_timer_dec;
    logic w_timer_zero;
    logic w_done_next;

`ifdef SIMPLE_SPLIT_CTRL_FLUSH_EN
    logic r_last_dest;
`endif

    assign w_accept     = cmd_valid && r_cmd_ready;
    assign w_cmd_start  = w_accept && (cmd_vol != '0);
    assign w_cmd_reject = w_accept && (cmd_vol == '0);
    assign w_vol_zero   = (r_vol_cnt == '0);
    assign w_dest_next  = w_cmd_start ? cmd_dest : r_cmd_dest;

    split_settle_timer u_settle (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_timer_load),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (w_timer_dec),
        .o_zero     (w_timer_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and settle-timer control.
    always_comb begin
        w_state_next = r_state;
        w_timer_load = 1'b0;
        w_timer_dec  = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_start) begin
                    w_timer_load = 1'b1;
`ifdef SIMPLE_SPLIT_CTRL_FLUSH_EN
                    w_state_next = (cmd_dest != r_last_dest) ? ST_FLUSH : ST_OPEN;
`else
                    w_state_next = ST_OPEN;
`endif
                end
            end
`ifdef SIMPLE_SPLIT_CTRL_FLUSH_EN
            ST_FLUSH: begin
                w_timer_dec = 1'b1;
                if (w_timer_zero) begin
                    w_timer_load = 1'b1;
                    w_state_next = ST_OPEN;
                end
            end
`endif
            ST_OPEN: begin
                w_timer_dec = 1'b1;
                if (w_timer_zero) begin
                    w_state_next = ST_FLOW;
                end
            end
            ST_FLOW: begin
                if (w_vol_zero) begin
                    w_timer_load = 1'b1;
                    w_state_next = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                w_timer_dec = 1'b1;
                if (w_timer_zero) begin
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the command and count down the flow phase (loaded with vol-1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_dest <= DEST_A;
            r_vol_cnt  <= '0;
        end else if (w_cmd_start) begin
            r_cmd_dest <= cmd_dest;
            r_vol_cnt  <= cmd_vol - VOL_W'(1);
        end else if ((r_state == ST_FLOW) && !w_vol_zero) begin
            r_vol_cnt  <= r_vol_cnt - VOL_W'(1);
        end
    end

`ifdef SIMPLE_SPLIT_CTRL_FLUSH_EN
    // Remember the outlet of the last completed command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_dest <= DEST_A;
        end else if (w_done_next) begin
            r_last_dest <= r_cmd_dest;
        end
    end
`endif

    // Registered outputs, decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_ready <= 1'b0;
            r_valve_in  <= 1'b0;
            r_valve_a   <= 1'b0;
            r_valve_b   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_next == ST_IDLE);
`ifdef SIMPLE_SPLIT_CTRL_FLUSH_EN
            r_valve_in  <= (w_state_next == ST_FLOW) || (w_state_next == ST_FLUSH);
`else
            r_valve_in  <= (w_state_next == ST_FLOW);
`endif
            r_valve_a   <= (w_state_next != ST_IDLE) && (w_dest_next == DEST_A);
            r_valve_b   <= (w_state_next != ST_IDLE) && (w_dest_next == DEST_B);
            r_busy      <= (w_state_next != ST_IDLE);
            r_done      <= w_done_next;
            r_err       <= w_cmd_reject;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign valve_in  = r_valve_in;
    assign valve_a   = r_valve_a;
    assign valve_b   = r_valve_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_simple_split_ctrl.sv
// Testbench for simple_split_ctrl: directed timeline scenarios plus a random
// command stream compared against a per-command timeline model.
module tb_simple_split_ctrl;

    localparam int S  = 4;
    localparam int VW = 8;
`ifdef SIMPLE_SPLIT_CTRL_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_dest  = 1'b0;
    logic [VW-1:0] cmd_vol   = '0;
    logic          cmd_ready;
    logic          valve_in;
    logic          valve_a;
    logic          valve_b;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    simple_split_ctrl #(.SETTLE_CYC(S), .VOL_W(VW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dest  (cmd_dest),
        .cmd_vol   (cmd_vol),
        .valve_in  (valve_in),
        .valve_a   (valve_a),
        .valve_b   (valve_b),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Outlet valves must never be open together.
    always @(negedge clk) begin
        checks++;
        if (valve_a && valve_b) begin
            errors++;
            $display("FAIL excl: valve_a=%0b valve_b=%0b both open at %0t", valve_a, valve_b, $time);
        end
    end

    // ---------------- timeline reference model ----------------
    bit m_active;
    int m_start, m_dest, m_vol, m_flush, m_total, m_last, m_err_cyc;
    logic e_vin, e_a, e_b, e_busy, e_done, e_err, e_ready;

    task automatic model_reset();
        m_active  = 0;
        m_last    = 0;
        m_err_cyc = -1;
    endtask

    // Expected outputs in cycle cyc, counted from the accept cycle.
    task automatic model_eval(input int cyc);
        int k;
        e_done = 1'b0;
        if (m_active && cyc >= m_start + m_total) begin
            m_active = 0;
            m_last   = m_dest;
            e_done   = (cyc == m_start + m_total);
        end
        e_err   = (cyc == m_err_cyc);
        e_busy  = m_active;
        e_ready = !m_active;
        e_vin   = 1'b0;
        e_a     = 1'b0;
        e_b     = 1'b0;
        if (m_active) begin
            k     = cyc - m_start;
            e_vin = (k <= m_flush) || (k > m_flush + S && k <= m_flush + S + m_vol);
            e_a   = (m_dest == 0);
            e_b   = (m_dest == 1);
        end
    endtask

    task automatic model_accept(input int cyc);
        if (e_ready && cmd_valid) begin
            if (cmd_vol == 0) begin
                m_err_cyc = cyc + 1;
            end else begin
                m_active = 1;
                m_start  = cyc;
                m_dest   = int'(cmd_dest);
                m_vol    = int'(cmd_vol);
                m_flush  = (FLUSH_ON && m_dest != m_last) ? S : 0;
                m_total  = m_flush + 2 * S + m_vol + 1;
            end
            $display("cmd cycle=%0d dest=%0d vol=%0d", cyc, cmd_dest, cmd_vol);
        end
    endtask

    // Reset pulse; returns just after the first edge with rst_n released.
    task automatic apply_reset();
        cmd_valid = 1'b0;
        cmd_dest  = 1'b0;
        cmd_vol   = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        checks++;
        if ({valve_in, valve_a, valve_b, busy, done, err, cmd_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000000", {valve_in, valve_a, valve_b, busy, done, err, cmd_ready});
        end
        apply_reset();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b want ready=1 busy=0", cmd_ready, busy);
        end
        $display("reset released");
    endtask

    task automatic test_basic();
        cmd_valid = 1'b1; cmd_dest = 1'b0; cmd_vol = 8'd3;
        $display("cmd dest=0 vol=3 driven at cycle 0");
        for (int t = 0; t <= 14; t++) begin
            @(negedge clk);
            checks++;
            if (valve_a !== (t >= 1 && t <= 11) || valve_b !== 1'b0 ||
                valve_in !== (t >= 5 && t <= 7) || done !== (t == 12) ||
                busy !== (t >= 1 && t <= 11)) begin
                errors++;
                $display("FAIL basic t=%0d: a=%b b=%b in=%b done=%b busy=%b", t, valve_a, valve_b, valve_in, done, busy);
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic test_zero_vol();
        cmd_valid = 1'b1; cmd_dest = 1'b1; cmd_vol = 8'd0;
        $display("cmd dest=1 vol=0 driven at cycle 0");
        for (int t = 0; t <= 3; t++) begin
            @(negedge clk);
            checks++;
            if (err !== (t == 1) || {valve_in, valve_a, valve_b, busy} !== 4'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL zero_vol t=%0d: err=%b valves=%b%b%b busy=%b ready=%b", t, err, valve_in, valve_a, valve_b, busy, cmd_ready);
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done = 0;
        cmd_valid = 1'b1; cmd_dest = 1'b0; cmd_vol = 8'd3;
        $display("cmd dest=0 vol=3 driven at cycle 0, reset in cycle 6");
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        checks++;
        if (valve_a !== 1'b1 || valve_in !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: a=%b in=%b want a=1 in=1", valve_a, valve_in);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valve_in, valve_a, valve_b, busy, done, cmd_ready} !== 6'b0) begin
            errors++;
            $display("FAIL abort_async: got %b want 000000", {valve_in, valve_a, valve_b, busy, done, cmd_ready});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: ready=%b want 1", cmd_ready);
        end
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1;
        end
        @(posedge clk); #1;
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: saw done/busy=1 want 0");
        end
    endtask

    task automatic test_back_to_back();
        int acc_t  = -1;
        int done_t = -1;
        cmd_valid = 1'b1; cmd_dest = 1'b0; cmd_vol = 8'd3;
        $display("cmd dest=0 vol=3 at cycle 0, second cmd vol=5 held valid");
        for (int t = 0; t <= 40; t++) begin
            @(negedge clk);
            if (t >= 1 && acc_t < 0 && cmd_ready === 1'b1 && cmd_valid) acc_t = t;
            if (acc_t > 0 && t > acc_t && done === 1'b1 && done_t < 0) done_t = t;
            if (t == 13) begin
                checks++;
                if (busy !== 1'b1 || valve_a !== 1'b1 || cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second_start: busy=%b a=%b ready=%b", busy, valve_a, cmd_ready);
                end
            end
            @(posedge clk); #1;
            if (t == 0) cmd_vol = 8'd5;
            if (acc_t > 0) cmd_valid = 1'b0;
        end
        checks++;
        if (acc_t != 12) begin
            errors++;
            $display("FAIL b2b_accept: accepted cycle %0d want 12", acc_t);
        end
        checks++;
        if (done_t != 26) begin
            errors++;
            $display("FAIL b2b_done: done cycle %0d want 26", done_t);
        end
    endtask

    task automatic test_dest_change();
        int f      = FLUSH_ON ? S : 0;
        int done_u = -1;
        apply_reset();
        cmd_valid = 1'b1; cmd_dest = 1'b0; cmd_vol = 8'd2;
        $display("cmd dest=0 vol=2 at cycle 0, then dest=1 vol=2 held valid");
        for (int t = 0; t <= 35; t++) begin
            int u = t - 11;
            @(negedge clk);
            if (u >= 1 && u <= 10) begin
                checks++;
                if (valve_b !== 1'b1 || valve_a !== 1'b0 ||
                    valve_in !== ((u <= f) || (u > f + S && u <= f + S + 2))) begin
                    errors++;
                    $display("FAIL dest_change u=%0d: a=%b b=%b in=%b", u, valve_a, valve_b, valve_in);
                end
            end
            if (u >= 1 && done === 1'b1 && done_u < 0) done_u = u;
            @(posedge clk); #1;
            if (t == 0) cmd_dest = 1'b1;
            if (t == 11) cmd_valid = 1'b0;
        end
        checks++;
        if (done_u != f + 2 * S + 3) begin
            errors++;
            $display("FAIL dest_change_done: done at u=%0d want %0d", done_u, f + 2 * S + 3);
        end
    endtask

    task automatic test_random();
        int nprint = 0;
        int r;
        apply_reset();
        model_reset();
        for (int c = 0; c < 10000; c++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_dest  = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r == 0)      cmd_vol = '0;
            else if (r == 1) cmd_vol = VW'($urandom_range(1, 255));
            else             cmd_vol = VW'($urandom_range(1, 8));
            @(negedge clk);
            model_eval(c);
            checks++;
            if ({valve_in, valve_a, valve_b, busy, done, err, cmd_ready} !==
                {e_vin, e_a, e_b, e_busy, e_done, e_err, e_ready}) begin
                errors++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL random cyc=%0d: in,a,b,busy,done,err,ready got %b want %b", c,
                             {valve_in, valve_a, valve_b, busy, done, err, cmd_ready},
                             {e_vin, e_a, e_b, e_busy, e_done, e_err, e_ready});
                end
            end
            model_accept(c);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_vol();
        test_reset_abort();
        test_back_to_back();
        test_dest_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simple_split_ctrl.md
SIMPLE_SPLIT_CTRL -- requirements
Module: simple_split_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 4: valve settle time in clock cycles; legal range 1..255.
REQ-002 Parameter VOL_W, default 8: width of the dispense-volume field, in flow ticks.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port cmd_valid, input, 1: dispense command present.
REQ-006 Port cmd_ready, output, 1: block accepts a command this cycle.
REQ-007 Port cmd_dest, input, 1: splitter outlet select; 0 = outlet A, 1 = outlet B.
REQ-008 Port cmd_vol, input, VOL_W: number of cycles the inlet valve is held open.
REQ-009 Port valve_in, output, 1: inlet valve drive; 1 = open.
REQ-010 Port valve_a, output, 1: outlet A valve drive; 1 = open.
REQ-011 Port valve_b, output, 1: outlet B valve drive; 1 = open.
REQ-012 Port busy, output, 1: high whenever the state is not IDLE.
REQ-013 Port done, output, 1: one-cycle pulse on command completion.
REQ-014 Port err, output, 1: one-cycle pulse when a zero-volume command is rejected.

Function
REQ-015 The FSM SHALL have states IDLE, OPEN, FLOW, CLOSE; FLUSH exists only under the configuration macro.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle where cmd_valid and cmd_ready are both 1; cmd_dest and cmd_vol are latched on that cycle.
REQ-017 Accept with cmd_vol != 0 at cycle T: the FSM SHALL enter OPEN at T+1, with the selected outlet valve open and valve_in closed.
REQ-018 OPEN SHALL last exactly SETTLE_CYC cycles, then FLOW.
REQ-019 FLOW SHALL last exactly cmd_vol cycles with valve_in = 1 and the selected outlet open, then CLOSE.
REQ-020 CLOSE SHALL last exactly SETTLE_CYC cycles with valve_in = 0 and the outlet still open.
REQ-021 After CLOSE, the FSM SHALL return to IDLE with all valves closed; done pulses in that first IDLE cycle.
REQ-022 Accept with cmd_vol == 0: err SHALL pulse on the next cycle, no valve SHALL move, and the FSM SHALL stay in IDLE.
REQ-023 valve_a and valve_b SHALL never both be 1; valve_in SHALL be 1 only in FLOW (or FLUSH).
REQ-024 cmd_valid, cmd_dest and cmd_vol SHALL be ignored while busy; no command queuing.
REQ-025 All outputs SHALL be registered; the settle counter is 8 bits and the volume counter is VOL_W bits, both down-counting with no wrap.

Reset
REQ-026 On rst_n low, regardless of state, the block SHALL immediately drive valve_in, valve_a, valve_b, busy, done and err to 0, set the state to IDLE, and clear the last-destination register to 0 (outlet A).
REQ-027 cmd_ready SHALL be 0 during reset and 1 in the first clock cycle after rst_n deasserts.
REQ-028 A reset during any non-IDLE state SHALL abort the command without a done pulse.

Configuration
REQ-029 Macro SIMPLE_SPLIT_CTRL_FLUSH_EN: when defined, an accepted command whose cmd_dest differs from the last completed destination SHALL enter FLUSH for SETTLE_CYC cycles before OPEN.
REQ-030 FLUSH behaviour: valve_in = 1 and the new outlet open, purging the junction.
REQ-031 Without the macro, FLUSH SHALL not exist and destination changes SHALL add no cycles.

Structure
REQ-032 Package simple_split_pkg SHALL hold the state enum and the outlet encoding constants DEST_A = 0 and DEST_B = 1.
REQ-033 Sub-module split_settle_timer (loadable 8-bit down-counter with a zero flag) SHALL time the OPEN, CLOSE and FLUSH states.

Verification (SETTLE_CYC = 4)
REQ-034 Accept dest = 0, vol = 3 at cycle 0 -> valve_a = 1 in cycles 1..11, valve_in = 1 in cycles 5..7, done in cycle 12, valve_b = 0 throughout.
REQ-035 Accept vol = 0 -> err pulses in cycle 1; all valves stay 0; cmd_ready stays 1.
REQ-036 Drive rst_n = 0 in cycle 6 of the REQ-034 command -> all valves go to 0 asynchronously; no done; cmd_ready = 1 after release.
REQ-037 Hold cmd_valid high with a new command throughout the REQ-034 command -> the second command is accepted only in cycle 12.
REQ-038 With FLUSH_EN: dest 0 then dest 1 (vol = 2) -> second command shows 4 FLUSH cycles with valve_b = 1 and valve_in = 1 before OPEN; without the macro, no FLUSH.
REQ-039 Random command stream, 10k cycles -> assertion that valve_a and valve_b are never both 1 never fires.
